l1c_tag_ctrl: RTL and testbench

Tag-lookup and refill controller for the direct-mapped L1 cache; sits directly upstream of the 64×22 tag SRAM wrapper and drives its CS/OE/WEB/A/DI while consuming DO. Splits each 32-bit request address into tag/index/offset and keeps per-line valid bits in flops. Decides hit/miss, sequences line refills through a valid/ack handshake to the memory-side block, and writes the new tag on fill. Downstream, data-array control uses its response pulse.

---
 rtl/l1c_pkg.sv | 34 +++
 rtl/l1c_valid_bits.sv | 30 +++
 rtl/l1c_tag_ctrl.sv | 149 ++++++++++++++
 tb/tb_l1c_tag_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1c_pkg.sv
// Shared types and helpers for the L1 cache tag controller:
// geometry constants, controller state encoding and address-field extraction.
package l1c_pkg;

  localparam int L1C_TAG_W = 22;
  localparam int L1C_IDX_W = 6;
  localparam int L1C_OFF_W = 4;
  localparam int L1C_LINES = 1 << L1C_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REFILL = 2'd2,
    FILL   = 2'd3
  } l1c_state_e;

  function automatic logic [L1C_TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: L1C_TAG_W];
  endfunction

  function automatic logic [L1C_IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[L1C_OFF_W +: L1C_IDX_W];
  endfunction

  function automatic logic [L1C_OFF_W-1:0] addr_off(input logic [31:0] a);
    return a[L1C_OFF_W-1:0];
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/l1c_valid_bits.sv
// Per-line valid flags: set one line on fill, flash-clear all, combinational read.
module l1c_valid_bits #(
  parameter int IDX_W  = 6,
  parameter int NLINES = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_val
);

  logic [NLINES-1:0] vbits;

  // Flash clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbits <= '0;
    end else if (clr) begin
      vbits <= '0;
    end else if (set_en) begin
      vbits[set_idx] <= 1'b1;
    end
  end

  assign rd_val = vbits[rd_idx];

endmodule

// File: rtl/l1c_tag_ctrl.sv
// Direct-mapped L1 tag lookup / refill controller driving the 64x22 tag SRAM.
// Loads miss into a refill + tag write; stores that miss bypass (no allocate).
module l1c_tag_ctrl
  import l1c_pkg::*;
#(
  parameter int TAG_W = L1C_TAG_W,
  parameter int IDX_W = L1C_IDX_W,
  parameter int OFF_W = L1C_OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  input  logic             req_write,
  output logic             req_ready,
  input  logic             invalidate_all,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             refill_req,
  output logic [31:0]      refill_addr,
  input  logic             refill_ack,
  output logic             TA_CS,
  output logic             TA_OE,
  output logic             TA_WEB,
  output logic [IDX_W-1:0] TA_A,
  output logic [TAG_W-1:0] TA_DI,
  input  logic [TAG_W-1:0] TA_DO,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);

  l1c_state_e       state;
  logic [31:0]      addr_q;
  logic             write_q;
  logic             inv_pending;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             line_valid;
  logic             tag_hit;
  logic             inv_now;

  assign tag_q     = addr_tag(addr_q);
  assign idx_q     = addr_idx(addr_q);
  assign req_ready = (state == IDLE) && !invalidate_all && !inv_pending;
  assign accept    = req_valid && req_ready;
  assign tag_hit   = line_valid && (TA_DO == tag_q);
  // A deferred invalidate is applied on the first IDLE cycle, blocking intake.
  assign inv_now   = (state == IDLE) && (invalidate_all || inv_pending);

  l1c_valid_bits #(.IDX_W(IDX_W)) u_valid (
    .clk     (clk),
    .rst     (rst),
    .set_en  (state == FILL),
    .set_idx (idx_q),
    .clr     (inv_now),
    .rd_idx  (idx_q),
    .rd_val  (line_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      inv_pending <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (state == IDLE)
        inv_pending <= 1'b0;
      else if (invalidate_all)
        inv_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (tag_hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
            state     <= IDLE;
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state      <= write_q ? IDLE : REFILL;
          end
        end
        REFILL: begin
          if (refill_ack)
            state <= FILL;
        end
        FILL: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes and the response pulse decode straight from state so the
  // read launches in the accept cycle and the hit answer lands in CHECK.
  always_comb begin
    TA_CS      = 1'b0;
    TA_OE      = 1'b0;
    TA_WEB     = 1'b1;
    TA_A       = '0;
    TA_DI      = '0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          TA_CS = 1'b1;
          TA_OE = 1'b1;
          TA_A  = addr_idx(req_addr);
        end
      end
      CHECK: begin
        if (tag_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
        end else if (write_q) begin
          resp_valid = 1'b1;
        end
      end
      FILL: begin
        TA_CS      = 1'b1;
        TA_WEB     = 1'b0;
        TA_A       = idx_q;
        TA_DI      = tag_q;
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign refill_req  = (state == REFILL);
  assign refill_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_l1c_tag_ctrl.sv
// Randomised + directed bench for l1c_tag_ctrl against a line-level cache model
// (valid/tag arrays and hit/miss counts) with a behavioural tag SRAM attached.
module tb_l1c_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready, invalidate_all;
  logic [31:0] req_addr;
  logic        resp_valid, resp_hit, refill_req, refill_ack;
  logic [31:0] refill_addr, hit_cnt, miss_cnt;
  logic        TA_CS, TA_OE, TA_WEB;
  logic [5:0]  TA_A;
  logic [21:0] TA_DI, TA_DO;

  always #5 clk = ~clk;

  l1c_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
    .req_ready(req_ready), .invalidate_all(invalidate_all),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
    .TA_CS(TA_CS), .TA_OE(TA_OE), .TA_WEB(TA_WEB), .TA_A(TA_A),
    .TA_DI(TA_DI), .TA_DO(TA_DO),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Tag SRAM: synchronous write, registered read data; starts with junk.
  logic [21:0] mem [64];
  logic [21:0] dout;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 22'($urandom);
    dout = '0;
  end
  always @(posedge clk) begin
    if (TA_CS && !TA_WEB)     mem[TA_A] <= TA_DI;
    else if (TA_CS && TA_OE)  dout <= mem[TA_A];
  end
  assign TA_DO = dout;

  // Reference model: what the cache should hold, line by line.
  bit          mv [64];
  logic [21:0] mt [64];
  logic [31:0] mhit, mmiss;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  // One request, start to finish, with every cycle's outputs checked.
  task automatic do_req(input logic [31:0] addr, input bit wr, input int ackd,
                        input bit inv_mid, input bit rst_mid);
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          exp_hit;
    idx = addr[9:4];
    tg  = addr[31:10];
    @(negedge clk); #1;
    wait_ready();
    chk("hit_cnt", hit_cnt, mhit);
    chk("miss_cnt", miss_cnt, mmiss);
    exp_hit = mv[idx] && (mt[idx] == tg);
    req_valid = 1; req_addr = addr; req_write = wr;
    #1;
    chk("rd_ctl", {TA_CS, TA_OE, TA_WEB}, 3'b111);
    chk("rd_a", TA_A, idx);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_write = $urandom;
    #1;
    chk("chk_refill_req", refill_req, 0);
    if (exp_hit) begin
      chk("hit_resp", {resp_valid, resp_hit}, 2'b11);
      mhit = sat(mhit);
    end else if (wr) begin
      chk("st_miss_resp", {resp_valid, resp_hit}, 2'b10);
      mmiss = sat(mmiss);
    end else begin
      chk("ld_miss_noresp", resp_valid, 0);
      mmiss = sat(mmiss);
      @(negedge clk); #1;
      for (int k = 0; k <= ackd; k++) begin
        chk("refill_req", refill_req, 1);
        chk("refill_addr", refill_addr, {addr[31:4], 4'h0});
        chk("refill_noresp", resp_valid, 0);
        if (rst_mid) begin
          rst = 1; #1;
          chk("rst_refill_req", refill_req, 0);
          chk("rst_hit_cnt", hit_cnt, 0);
          chk("rst_miss_cnt", miss_cnt, 0);
          chk("rst_ctl", {TA_CS, TA_OE, TA_WEB}, 3'b001);
          model_clear(); mhit = 0; mmiss = 0;
          @(negedge clk); rst = 0;
          return;
        end
        if (k == ackd) refill_ack = 1;
        if (inv_mid && k == 0) invalidate_all = 1;
        @(posedge clk);
        @(negedge clk);
        refill_ack = 0; invalidate_all = 0;
        #1;
      end
      chk("fill_ctl", {TA_CS, TA_WEB}, 2'b10);
      chk("fill_a", TA_A, idx);
      chk("fill_di", TA_DI, tg);
      chk("fill_resp", {resp_valid, resp_hit, refill_req}, 3'b100);
      mv[idx] = 1; mt[idx] = tg;
      if (inv_mid) begin
        @(negedge clk); #1;
        chk("inv_pend_ready", req_ready, 0);
        model_clear();
      end
    end
  endtask

  task automatic inv_idle();
    @(negedge clk); #1;
    invalidate_all = 1; req_valid = 1; req_addr = 32'h0000_1230; req_write = 0;
    #1;
    chk("inv_idle_ready", req_ready, 0);
    chk("inv_idle_cs", TA_CS, 0);
    @(posedge clk);
    @(negedge clk);
    invalidate_all = 0; req_valid = 0;
    model_clear();
  endtask

  task automatic stray_ack();
    @(negedge clk); #1;
    refill_ack = 1;
    @(posedge clk);
    @(negedge clk);
    refill_ack = 0; #1;
    chk("stray_ack_req", refill_req, 0);
    chk("stray_ack_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_addr = 0; req_write = 0;
    invalidate_all = 0; refill_ack = 0;
    model_clear(); mhit = 0; mmiss = 0;
    for (int i = 0; i < 64; i++) mt[i] = '0;
    #12;
    chk("rst_resp", {resp_valid, resp_hit, refill_req}, 3'b000);
    chk("rst_ctl", {TA_CS, TA_OE, TA_WEB}, 3'b001);
    chk("rst_a_di", {TA_A, TA_DI}, 0);
    chk("rst_raddr", refill_addr, 0);
    chk("rst_cnts", {hit_cnt[15:0], miss_cnt[15:0]}, 0);
    @(negedge clk); rst = 0; #1;
    chk("rst_ready", req_ready, 1);

    // Cold load, refill after 3 cycles, then re-load hits.
    do_req(32'h0000_1230, 0, 3, 0, 0);
    do_req(32'h0000_1230, 0, 0, 0, 0);
    // Store miss bypasses; a following load of that line still misses.
    do_req(32'h0000_4560, 1, 0, 0, 0);
    do_req(32'h0000_4560, 0, 1, 0, 0);
    // Index conflict: 0x400 and 0x800 share index 0.
    do_req(32'h0000_0400, 0, 0, 0, 0);
    do_req(32'h0000_0800, 0, 2, 0, 0);
    do_req(32'h0000_0400, 0, 0, 0, 0);
    do_req(32'h0000_0400, 1, 0, 0, 0);
    // Invalidate during refill: fill lands, then the line is cleared.
    do_req(32'h0000_9990, 0, 2, 1, 0);
    do_req(32'h0000_9990, 0, 0, 0, 0);
    inv_idle();
    do_req(32'h0000_9990, 1, 0, 0, 0);
    stray_ack();
    // Reset in the middle of a refill.
    do_req(32'h0000_7770, 0, 2, 0, 1);
    do_req(32'h0000_7770, 0, 0, 0, 0);
    do_req(32'h0000_7770, 0, 0, 0, 0);

    // Saturation: preload hit counter at all-ones, then hit again.
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    mhit = 32'hFFFF_FFFF;
    #1;
    chk("sat_preload", hit_cnt, 32'hFFFF_FFFF);
    do_req(32'h0000_7770, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sat_hold", hit_cnt, 32'hFFFF_FFFF);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = {20'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 7)), 4'($urandom)};
      if ($urandom_range(0, 24) == 0) inv_idle();
      if ($urandom_range(0, 19) == 0) stray_ack();
      do_req(a, ($urandom_range(0, 3) == 0), $urandom_range(0, 4),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
    end
    @(negedge clk); #1;
    chk("final_hit_cnt", hit_cnt, mhit);
    chk("final_miss_cnt", miss_cnt, mmiss);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
